// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, SRAM data width and clog2 helper for the MEM-stage SRAM controller
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int SRAM_DW = 16;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: per-beat wait counter and beat index for multi-beat SRAM accesses
module sram_beat_timer
  import mem_stage_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int BEATS = 2,
  localparam int BW = BEATS > 1 ? clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  output logic [BW-1:0] beat,
  output logic          last_cycle,
  output logic          last_beat
);
  logic [2:0] wait_cnt;
  assign last_cycle = wait_cnt == 3'(WAIT_STATES);
  assign last_beat = beat == BW'(BEATS - 1);
  always_ff @(posedge clk)
    if (!rst || start) begin
      wait_cnt <= '0;
      beat <= '0;
    end else if (run) begin
      wait_cnt <= last_cycle ? '0 : wait_cnt + 3'd1;
      beat <= last_cycle ? (last_beat ? '0 : beat + BW'(1)) : beat;
    end
endmodule

// File: rtl/mem_stage_sram_wide.sv
// mem_stage_sram_wide: splits one DATA_W pipeline load/store into 16-bit SRAM beats, stalling via freeze
module mem_stage_sram_wide
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SRAM_AW = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ALU_result,
  input  logic [DATA_W-1:0]   ST_val,
  input  logic [DATA_W/8-1:0] MEM_BE,
  input  logic                MEM_R_en,
  input  logic                MEM_W_en,
  output logic [DATA_W-1:0]   MEM_R_value,
  output logic                freeze,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);
  localparam int BEATS = DATA_W / SRAM_DW;
  localparam int BW = BEATS > 1 ? clog2(BEATS) : 1;
  localparam int AL = clog2(DATA_W / 8);
  state_t state, next;
  logic [31:0] base_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W/8-1:0] be_q;
  logic wr_q, req, idle, acc, wr_beat, last_cycle, last_beat;
  logic [BW-1:0] beat;
  logic [1:0] pair;
  assign req = MEM_R_en | MEM_W_en;
  assign idle = state == IDLE;
  // Pins are gated by rst so an access aborted by reset cannot write during the reset cycle.
  assign acc = rst && state == ACCESS;
  assign wr_beat = acc && wr_q;
  assign pair = be_q[2*beat +: 2];
  sram_beat_timer #(.WAIT_STATES(WAIT_STATES), .BEATS(BEATS)) timer (
    .clk(clk), .rst(rst), .start(idle), .run(state == ACCESS),
    .beat(beat), .last_cycle(last_cycle), .last_beat(last_beat)
  );
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb
    next = idle ? (req ? ACCESS : IDLE) :
           state == ACCESS ? (last_cycle && last_beat ? DONE : ACCESS) : IDLE;
  always_ff @(posedge clk)
    if (!rst) begin
      MEM_R_value <= '0;
      base_q <= '0;
      data_q <= '0;
      be_q <= '0;
      wr_q <= 1'b0;
    end else begin
      if (idle && req) begin
        base_q <= (ALU_result >> AL) * 32'(BEATS);
        data_q <= ST_val;
        be_q <= MEM_BE;
        wr_q <= MEM_W_en;
      end
      if (acc && !wr_q && last_cycle) MEM_R_value[SRAM_DW*beat +: SRAM_DW] <= SRAM_DQ;
    end
  assign freeze = rst && ((idle && req) || state == ACCESS);
  assign SRAM_ADDR = acc ? SRAM_AW'(base_q + 32'(beat)) : '0;
  assign SRAM_CE_N = ~acc;
  assign SRAM_OE_N = ~(acc && !wr_q);
  assign SRAM_WE_N = ~(wr_beat && |pair);
  assign SRAM_LB_N = ~(acc && (!wr_q || pair[0]));
  assign SRAM_UB_N = ~(acc && (!wr_q || pair[1]));
  assign SRAM_DQ = wr_beat ? data_q[SRAM_DW*beat +: SRAM_DW] : 16'bz;
endmodule

// File: tb/tb_mem_stage_sram_wide.sv
// tb_mem_stage_sram_wide: random and directed checks of two controller configurations against a transaction-level memory model
module tb_mem_stage_sram_wide;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, sel = 1'b0, ren = 1'b1, wen = 1'b0;
  logic [31:0] alu = '0;
  logic [63:0] st = '0;
  logic [7:0] be = '0;
  logic [31:0] a_rv;
  logic [63:0] b_rv;
  logic a_freeze, b_freeze, a_ub, a_lb, a_we, a_ce, a_oe, b_ub, b_lb, b_we, b_ce, b_oe;
  logic [17:0] a_addr, b_addr;
  wire [15:0] a_dq, b_dq;
  logic [15:0] sram_a [0:262143] = '{default: 16'h0};
  logic [15:0] sram_b [0:262143] = '{default: 16'h0};
  mem_stage_sram_wide #(.DATA_W(32), .SRAM_AW(18), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .ALU_result(alu), .ST_val(st[31:0]), .MEM_BE(be[3:0]),
    .MEM_R_en(ren & !sel), .MEM_W_en(wen & !sel), .MEM_R_value(a_rv), .freeze(a_freeze),
    .SRAM_DQ(a_dq), .SRAM_ADDR(a_addr), .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb),
    .SRAM_WE_N(a_we), .SRAM_CE_N(a_ce), .SRAM_OE_N(a_oe)
  );
  mem_stage_sram_wide #(.DATA_W(64), .SRAM_AW(18), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .ALU_result(alu), .ST_val(st), .MEM_BE(be),
    .MEM_R_en(ren & sel), .MEM_W_en(wen & sel), .MEM_R_value(b_rv), .freeze(b_freeze),
    .SRAM_DQ(b_dq), .SRAM_ADDR(b_addr), .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb),
    .SRAM_WE_N(b_we), .SRAM_CE_N(b_ce), .SRAM_OE_N(b_oe)
  );
  assign a_dq = (!a_ce && !a_oe) ? sram_a[a_addr] : 16'bz;
  assign b_dq = (!b_ce && !b_oe) ? sram_b[b_addr] : 16'bz;
  always @(posedge clk) begin
    if (!a_ce && !a_we) begin
      if (!a_lb) sram_a[a_addr][7:0] <= a_dq[7:0];
      if (!a_ub) sram_a[a_addr][15:8] <= a_dq[15:8];
    end
    if (!b_ce && !b_we) begin
      if (!b_lb) sram_b[b_addr][7:0] <= b_dq[7:0];
      if (!b_ub) sram_b[b_addr][15:8] <= b_dq[15:8];
    end
  end
  wire freeze_s = sel ? b_freeze : a_freeze;
  wire [17:0] addr_s = sel ? b_addr : a_addr;
  wire [15:0] dq_s = sel ? b_dq : a_dq;
  wire [63:0] rv_s = sel ? b_rv : {32'h0, a_rv};
  wire [4:0] ctl_s = sel ? {b_ce, b_oe, b_we, b_ub, b_lb} : {a_ce, a_oe, a_we, a_ub, a_lb};
  int vectors = 0, errors = 0;
  logic [63:0] last_rv [2] = '{64'h0, 64'h0};
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input bit s, input int h);
    int k = (s ? 262144 : 0) + (h & 32'h3FFFF);
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0;
  endfunction
  task automatic ref_wr(input bit s, input int h, input logic [15:0] d, input logic [1:0] pr);
    int k = (s ? 262144 : 0) + (h & 32'h3FFFF);
    logic [15:0] v = ref_rd(s, h);
    if (pr[0]) v[7:0] = d[7:0];
    if (pr[1]) v[15:8] = d[15:8];
    ref_mem[k] = v;
  endtask
  task automatic op(input bit s, input bit w, input bit r, input logic [31:0] a,
                    input logic [63:0] d, input logic [7:0] bm, input bit hold);
    int beats = s ? 4 : 2, ws = s ? 0 : 1, n = 0, b, base;
    logic [63:0] exp_rv;
    logic [1:0] pr;
    logic [4:0] exp_ctl;
    logic [17:0] ea;
    bit done = 0;
    base = int'((a >> (s ? 3 : 2)) * 32'(beats));
    exp_rv = last_rv[s];
    if (!w) begin
      exp_rv = '0;
      for (int i = 0; i < beats; i++) exp_rv[16*i +: 16] = ref_rd(s, base + i);
    end
    @(negedge clk);
    sel = s; ren = r; wen = w; alu = a; st = d; be = bm;
    while (!done && n < 40) begin
      #1;
      if (!freeze_s) done = 1;
      else begin
        if (n > 0) begin
          b = (n - 1) / (ws + 1);
          ea = 18'(base + b);
          pr = bm[2*b +: 2];
          exp_ctl = w ? {1'b0, 1'b1, ~|pr, ~pr[1], ~pr[0]} : 5'b00100;
          vectors++;
          if ({addr_s, ctl_s} !== {ea, exp_ctl}) begin
            errors++;
            $display("FAIL pins inst=%0d cyc=%0d addr/ctl got %h/%b want %h/%b", s, n, addr_s, ctl_s, ea, exp_ctl);
          end
          if (w) begin
            vectors++;
            if (dq_s !== d[16*b +: 16]) begin
              errors++;
              $display("FAIL dq inst=%0d cyc=%0d got %h want %h", s, n, dq_s, d[16*b +: 16]);
            end
          end
        end
        n++;
        @(negedge clk);
      end
    end
    vectors++;
    if (!done || n != 1 + beats * (ws + 1)) begin
      errors++;
      $display("FAIL freeze_cycles inst=%0d got %0d want %0d (done=%0d)", s, n, 1 + beats * (ws + 1), done);
    end
    vectors++;
    if (rv_s !== exp_rv) begin
      errors++;
      $display("FAIL r_value inst=%0d addr=%h got %h want %h", s, a, rv_s, exp_rv);
    end
    vectors++;
    if (ctl_s !== 5'b11111) begin
      errors++;
      $display("FAIL done_pins inst=%0d got %b want 11111", s, ctl_s);
    end
    if (!hold) begin ren = 0; wen = 0; end
    last_rv[s] = exp_rv;
    if (w) for (int i = 0; i < beats; i++) ref_wr(s, base + i, d[16*i +: 16], bm[2*i +: 2]);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({a_freeze, a_ce, a_oe, a_we, a_ub, a_lb, a_addr, a_rv} !== {1'b0, 5'b11111, 18'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_a got frz=%b ctl=%b addr=%h rv=%h want 0/11111/0/0", a_freeze, {a_ce, a_oe, a_we, a_ub, a_lb}, a_addr, a_rv);
    end
    vectors++;
    if ({b_freeze, b_ce, b_oe, b_we, b_ub, b_lb, b_addr, b_rv} !== {1'b0, 5'b11111, 18'h0, 64'h0}) begin
      errors++;
      $display("FAIL reset_b got frz=%b ctl=%b addr=%h rv=%h want 0/11111/0/0", b_freeze, {b_ce, b_oe, b_we, b_ub, b_lb}, b_addr, b_rv);
    end
    ren = 0;
    rst = 1;
  endtask
  task automatic test_write_read;
    op(0, 1, 0, 32'h10, 64'hDEADBEEF, 8'hF, 0);
    op(0, 0, 1, 32'h10, 64'h0, 8'h0, 0);
  endtask
  task automatic test_byte_enable;
    op(0, 1, 0, 32'h10, 64'h12345678, 8'b0100, 0);
    op(0, 0, 1, 32'h13, 64'h0, 8'h0, 0);
    op(1, 1, 0, 32'h80, 64'h0123_4567_89AB_CDEF, 8'b1000_0010, 0);
    op(1, 0, 1, 32'h80, 64'h0, 8'h0, 0);
  endtask
  task automatic test_wrap;
    op(0, 1, 0, 32'h7FFFC, 64'hCAFEF00D, 8'hF, 0);
    op(0, 0, 1, 32'h7FFFC, 64'h0, 8'h0, 0);
    op(1, 1, 0, 32'h1FFFF8, 64'h1111_2222_3333_4444, 8'hFF, 0);
    op(1, 1, 0, 32'h200000, 64'h5555_6666_7777_8888, 8'hFF, 0);
    op(1, 0, 1, 32'h0, 64'h0, 8'h0, 0);
    op(1, 0, 1, 32'h1FFFF8, 64'h0, 8'h0, 0);
  endtask
  task automatic test_both_en;
    op(0, 1, 1, 32'h20, 64'h0BADC0DE, 8'hF, 0);
    op(0, 0, 1, 32'h20, 64'h0, 8'h0, 0);
  endtask
  task automatic test_back_to_back;
    op(0, 0, 1, 32'h10, 64'h0, 8'h0, 1);
    op(0, 1, 0, 32'h24, 64'hA5A55A5A, 8'hF, 1);
    op(0, 0, 1, 32'h24, 64'h0, 8'h0, 1);
    op(1, 0, 1, 32'h80, 64'h0, 8'h0, 0);
  endtask
  task automatic test_reset_abort;
    op(0, 1, 0, 32'h40, 64'h1111_2222, 8'hF, 0);
    @(negedge clk);
    sel = 0; wen = 1; ren = 0; alu = 32'h40; st = 64'hAAAA_BBBB; be = 8'hF;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    vectors++;
    if ({a_freeze, a_ce, a_oe, a_we, a_ub, a_lb, a_rv} !== {1'b0, 5'b11111, 32'h0}) begin
      errors++;
      $display("FAIL abort got frz=%b ctl=%b rv=%h want 0/11111/0", a_freeze, {a_ce, a_oe, a_we, a_ub, a_lb}, a_rv);
    end
    wen = 0;
    rst = 1;
    last_rv[0] = '0;
    last_rv[1] = '0;
    ref_wr(0, 32'h20, 16'hBBBB, 2'b11);
    op(0, 0, 1, 32'h40, 64'h0, 8'h0, 0);
  endtask
  task automatic test_random;
    logic [31:0] a;
    bit s, w, r;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      a = (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 32'h0020_0000 : 32'h0);
      op(s, w, r, a, {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    ren = 0;
    wen = 0;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_both_en();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
